// File: rtl/solver_pkg.sv
// Shared constants and helpers for the solver's coordinator slice.
package solver_pkg;

  // Width of the retired-digest counter.
  localparam int TRIES_W = 64;

  // Tile index width; a single tile still needs one bit of pointer.
  function automatic int tid_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [TRIES_W-1:0] sat_inc(input logic [TRIES_W-1:0] v);
    return (&v) ? v : v + TRIES_W'(1);
  endfunction

endpackage

// File: rtl/lowest_one_pick.sv
// Picks the lowest set bit of a request vector as a one-hot grant.
module lowest_one_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] onehot,
  output logic         any
);

  // Two's-complement trick isolates the lowest set bit; zero stays zero.
  always_comb begin
    onehot = req & (~req + N'(1));
    any    = |req;
  end

endmodule

// File: rtl/coordinator.sv
// Dispatches candidates round-robin to hashing tiles, retires their digests,
// and latches the message of the first tile that reports a match.
module coordinator
  import solver_pkg::*;
#(
  parameter int MSG_LEN = 1234,
  parameter int TILES   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cand_val_i,
  input  logic [MSG_LEN-1:0] cand_i,
  output logic               cand_rdy_o,
  output logic [TILES-1:0]   msg_val_o,
  output logic [MSG_LEN-1:0] msg_o,
  input  logic [TILES-1:0]   msg_rdy_i,
  input  logic [TILES-1:0]   dgst_val_i,
  input  logic [TILES-1:0]   dgst_i,
  output logic [TILES-1:0]   dgst_rdy_o,
  output logic [MSG_LEN-1:0] result_o,
  output logic               result_val_o,
  output logic [TRIES_W-1:0] tries_o
);

  localparam int TID_W = tid_w(TILES);

  logic [TID_W-1:0]   dp;
  logic [TILES-1:0]   busy;
  logic               found;
  logic [MSG_LEN-1:0] store [TILES];

  logic               en;
  logic               fire;
  logic [TILES-1:0]   fire_vec;
  logic [TILES-1:0]   eligible;
  logic               retire_any;
  logic               match_hit;
  logic [MSG_LEN-1:0] win_msg;

  assign msg_o        = cand_i;
  assign result_val_o = found;

  // Dispatch handshake toward the tile under the pointer; held quiet in reset.
  always_comb begin
    en         = ~rst_i & ~found & ~busy[dp];
    msg_val_o  = '0;
    msg_val_o[dp] = cand_val_i & en;
    cand_rdy_o = msg_rdy_i[dp] & en;
    fire       = cand_val_i & cand_rdy_o;
    fire_vec   = msg_val_o & {TILES{cand_rdy_o}};
  end

  // Only busy tiles may retire; a digest from an idle tile is ignored.
  always_comb begin
    eligible = dgst_val_i & busy & {TILES{~rst_i}};
  end

  lowest_one_pick #(.N(TILES)) u_pick (
    .req    (eligible),
    .onehot (dgst_rdy_o),
    .any    (retire_any)
  );

  // Message and match flag of the tile retiring this cycle.
  always_comb begin
    win_msg   = '0;
    match_hit = |(dgst_rdy_o & dgst_i);
    for (int i = 0; i < TILES; i++) begin
      if (dgst_rdy_o[i]) win_msg = win_msg | store[i];
    end
  end

  // Pointer, occupancy, stored copies, retire counter and sticky result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dp       <= '0;
      busy     <= '0;
      found    <= 1'b0;
      result_o <= '0;
      tries_o  <= '0;
      for (int i = 0; i < TILES; i++) store[i] <= '0;
    end else begin
      if (fire || busy[dp]) begin
        dp <= (dp == TID_W'(TILES - 1)) ? '0 : dp + TID_W'(1);
      end
      busy <= (busy | fire_vec) & ~dgst_rdy_o;
      for (int i = 0; i < TILES; i++) begin
        if (fire_vec[i]) store[i] <= cand_i;
      end
      if (retire_any) begin
        tries_o <= sat_inc(tries_o);
        if (match_hit && !found) begin
          found    <= 1'b1;
          result_o <= win_msg;
        end
      end
    end
  end

endmodule

// File: doc/coordinator.md
Name: coordinator

Overview:
- Sits between the candidate generator and the TILES hashing tiles inside the solver.
- Drives the tile-side message handshake and consumes the tile-side digest handshake.
- Each tile holds at most one message in flight; the coordinator keeps a copy of that message.
- On the first digest that reports a match, latches that tile's message as the result and stops dispatching.

Parameters:
- MSG_LEN, 1234, candidate message width in bits.
- TILES, 2, number of tiles (>=1); TID_W = max(1, $clog2(TILES)).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- cand_val_i  input  1  generator candidate valid.
- cand_i  input  MSG_LEN  candidate message.
- cand_rdy_o  output  1  candidate accepted this cycle.
- msg_val_o  output  TILES  per-tile message valid; at most one bit set.
- msg_o  output  MSG_LEN  message to tiles; equals cand_i.
- msg_rdy_i  input  TILES  per-tile message ready.
- dgst_val_i  input  TILES  per-tile digest result valid.
- dgst_i  input  TILES  per-tile match flag; 1 = masked digest matched.
- dgst_rdy_o  output  TILES  per-tile result accept; one-hot or zero.
- result_o  output  MSG_LEN  winning message.
- result_val_o  output  1  sticky found flag.
- tries_o  output  64  digests retired, saturating at all-ones.

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge) clears:
  - dispatch pointer dp=0; busy[]=0; found=0;
  - result_o=0; result_val_o=0; tries_o=0; stored messages=0.
  - Combinational outputs are then 0: msg_val_o, dgst_rdy_o, cand_rdy_o.
  - Reset mid-operation discards in-flight bookkeeping; tiles are reset by the same reset.
- Dispatch (combinational handshake, no added latency):
  - en = ~found & ~busy[dp].
  - msg_val_o[dp] = cand_val_i & en; all other bits 0.
  - cand_rdy_o = msg_rdy_i[dp] & en.
  - Fire = cand_val_i & cand_rdy_o. On fire: busy[dp]<=1, store[dp]<=cand_i, dp<=dp+1 (wraps TILES-1 -> 0).
  - If busy[dp] is set: dp advances by one with no fire, skipping busy tiles one per cycle.
  - If ~busy[dp] and no fire: dp holds.
  - msg_o = cand_i at all times.
- Collect:
  - Eligible e[i] = dgst_val_i[i] & busy[i].
  - dgst_rdy_o = one-hot of the lowest-index set bit of e, or zero. At most one retire per cycle.
  - On retire of tile k: busy[k]<=0, tries_o<=sat(tries_o+1).
  - On retire of tile k with dgst_i[k]=1 and found=0: found<=1, result_o<=store[k], result_val_o<=1.
  - result_val_o and result_o rise the cycle after the retiring edge; both hold until reset.
  - dgst_val_i from a non-busy tile is a protocol error: never accepted and never counted.
- Boundary conditions:
  - Dispatch and retire on the same tile in one cycle are impossible: dispatch needs ~busy, retire needs busy. Both use registered busy.
  - A tile retired at edge t is dispatchable from t+1.
  - Two tiles match in the same cycle: the lower index wins. The other tile retires next cycle, is counted, and does not change the result.
  - After found: cand_rdy_o=0 permanently; outstanding tiles still drain and are counted.
  - TILES=1: dp is constant 0; pointer logic degenerates.
  - tries_o saturates at 2^64-1 and never wraps.

Decomposition:
- solver_pkg: TID_W helper function, tries counter width constant (64), saturating-increment function.
- Sub-module lowest_one_pick #(N): combinational vector -> one-hot of lowest set bit plus any flag. Used for dgst_rdy_o.
- Everything else stays in coordinator.

Test Plan:
- All tests use TILES=2, MSG_LEN=8 unless stated.
- Reset: hold rst_i 2 cycles with cand_val_i=1 -> cand_rdy_o=0, msg_val_o=0, result_val_o=0, tries_o=0. After release, msg_val_o=2'b01 with msg_rdy_i=2'b11.
- Round-robin: stream 8'h11, 8'h22 with msg_rdy_i=11 -> 8'h11 to tile0, 8'h22 to tile1. Then cand_rdy_o=0 until a retire. Retire tile1 (dgst_i=0) -> tries_o=1; next candidate 8'h33 goes to tile1 after dp skips busy tile0.
- Match: tile0 holds 8'hA5 and returns dgst_val=01, dgst_i=01 -> next cycle result_val_o=1, result_o=8'hA5, cand_rdy_o stays 0 thereafter.
- Simultaneous: tiles hold 8'h01/8'h02, both return val=11, match=11 -> cycle1 dgst_rdy_o=01 and result 8'h01; cycle2 dgst_rdy_o=10, tries_o=2, result unchanged.
- Backpressure: msg_rdy_i[0]=0 for 5 cycles with dp=0 -> no fire, dp holds, cand_rdy_o=0. msg_rdy_i[0]=1 -> single fire to tile0.
- Mid-run reset, then spurious: with both tiles busy and found=1, assert rst_i -> next cycle all state clear, new dispatch allowed. A dgst_val_i on a non-busy tile -> dgst_rdy_o=0, tries_o unchanged.
